fast_line_buffer: RTL and testbench

Streaming window generator directly upstream of the FAST detector. Accepts raster-order pixels one per enabled cycle, keeps six previous image lines in on-chip line RAM, and assembles a 7x7 neighbourhood. Each cycle a fully in-frame window completes, it presents the 16 Bresenham-circle pixels, the centre pixel and the centre's coordinates to the corner test.

---
 rtl/fast_line_buffer.sv | 147 ++++++++++++++
 tb/tb_fast_line_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fast_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fast_line_buffer : 7x7 window generator feeding the FAST corner test.
// Optional macro FAST_LB_SOF_EN adds the sof port. Rev 1.0
// ============================================================================
module fast_line_buffer #(
  parameter int COL_NUM     = 640,
  parameter int ROW_NUM     = 480,
  parameter int PIXEL_WIDTH = 8,
  localparam int XW = $clog2(COL_NUM),
  localparam int YW = $clog2(ROW_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
`ifdef FAST_LB_SOF_EN
  input  logic                      sof,
`endif
  input  logic [PIXEL_WIDTH-1:0]    data_in,
  output logic [16*PIXEL_WIDTH-1:0] circle_out,
  output logic [PIXEL_WIDTH-1:0]    center_out,
  output logic [XW-1:0]             x_coord,
  output logic [YW-1:0]             y_coord,
  output logic                      win_valid
);

  // Circle slot -> (row, col) inside the 7x7 window, row 0 being the oldest line.
  localparam int CIR_R [16] = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0};
  localparam int CIR_C [16] = '{3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1, 2};

  logic                      sof_hit;
  logic [XW-1:0]             col_q, col_d, pos_col;
  logic [YW-1:0]             row_q, row_d, pos_row;
  logic [PIXEL_WIDTH-1:0]    ram_rd [6];
  logic [PIXEL_WIDTH-1:0]    win_q [7][7];
  logic [PIXEL_WIDTH-1:0]    win_d [7][7];
  logic [16*PIXEL_WIDTH-1:0] circle_q, circle_d;
  logic [PIXEL_WIDTH-1:0]    center_q, center_d;
  logic [XW-1:0]             x_q, x_d;
  logic [YW-1:0]             y_q, y_d;
  logic                      valid_q, valid_d;

`ifdef FAST_LB_SOF_EN
  assign sof_hit = ce & sof;
`else
  assign sof_hit = 1'b0;
`endif

  // Position of the pixel accepted this cycle; sof overrides the counters.
  assign pos_col = sof_hit ? '0 : col_q;
  assign pos_row = sof_hit ? '0 : row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (ce) begin
      if (pos_col == XW'(COL_NUM - 1)) begin
        col_d = '0;
        row_d = (pos_row == YW'(ROW_NUM - 1)) ? '0 : pos_row + YW'(1);
      end else begin
        col_d = pos_col + XW'(1);
        row_d = pos_row;
      end
    end
  end

  // Asynchronous-read line RAMs: the read of the old value and the write of the
  // new one share an address, which gives read-before-write at the clock edge.
  for (genvar k = 0; k < 6; k++) begin : g_line
    logic [PIXEL_WIDTH-1:0] mem_q [COL_NUM];
    logic [PIXEL_WIDTH-1:0] wr_data;
    if (k == 0) begin : g_first
      assign wr_data = data_in;
    end else begin : g_chain
      assign wr_data = ram_rd[k-1];
    end
    assign ram_rd[k] = mem_q[pos_col];
    always_ff @(posedge clk) begin
      if (ce) mem_q[pos_col] <= wr_data;
    end
  end

  always_comb begin
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        win_d[r][c] = win_q[r][c];
    if (ce) begin
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 6; c++)
          win_d[r][c] = win_q[r][c+1];
      for (int r = 0; r < 6; r++)
        win_d[r][6] = ram_rd[5-r];
      win_d[6][6] = data_in;
    end
  end

  // Outputs load from the next-state window so a pixel's window appears one cycle later.
  always_comb begin
    valid_d  = ce && (pos_col >= XW'(6)) && (pos_row >= YW'(6));
    circle_d = circle_q;
    center_d = center_q;
    x_d      = x_q;
    y_d      = y_q;
    if (valid_d) begin
      for (int i = 0; i < 16; i++)
        circle_d[i*PIXEL_WIDTH +: PIXEL_WIDTH] = win_d[CIR_R[i]][CIR_C[i]];
      center_d = win_d[3][3];
      x_d      = pos_col - XW'(3);
      y_d      = pos_row - YW'(3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      circle_q <= '0;
      center_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 7; c++)
          win_q[r][c] <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      circle_q <= circle_d;
      center_q <= center_d;
      x_q      <= x_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 7; c++)
          win_q[r][c] <= win_d[r][c];
    end
  end

  assign circle_out = circle_q;
  assign center_out = center_q;
  assign x_coord    = x_q;
  assign y_coord    = y_q;
  assign win_valid  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fast_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fast_line_buffer : randomized bench against an image-array reference model.
// Rev 1.0
// ============================================================================
module tb_fast_line_buffer;
  localparam int C  = 16;
  localparam int R  = 12;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
`ifdef FAST_LB_SOF_EN
  logic          sof;
`endif
  logic [PW-1:0] data_in;
  logic [16*PW-1:0] circle_out;
  logic [PW-1:0] center_out;
  logic [3:0]    x_coord;
  logic [3:0]    y_coord;
  logic          win_valid;

  fast_line_buffer #(.COL_NUM(C), .ROW_NUM(R), .PIXEL_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .ce(ce),
`ifdef FAST_LB_SOF_EN
    .sof(sof),
`endif
    .data_in(data_in), .circle_out(circle_out), .center_out(center_out),
    .x_coord(x_coord), .y_coord(y_coord), .win_valid(win_valid));

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int pulses  = 0;

  // Reference model: the image as fed so far and the expected output registers.
  logic [PW-1:0]    img [R][C];
  int               pc, pr;
  logic             e_valid;
  logic [16*PW-1:0] e_circle;
  logic [PW-1:0]    e_center;
  logic [3:0]       e_x, e_y;
  int dx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int dy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  task automatic check(input string tag, input logic [16*PW-1:0] obs, input logic [16*PW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        img[r][c] = 'x;
    pc = 0; pr = 0;
  endtask

  task automatic check_outputs();
    check("win_valid", win_valid, e_valid);
    check("center_out", center_out, e_center);
    check("x_coord", x_coord, e_x);
    check("y_coord", y_coord, e_y);
    check("circle_out", circle_out, e_circle);
  endtask

  task automatic step(input logic c, input logic [PW-1:0] d, input logic s);
    int cx, cy;
    ce = c;
    data_in = d;
`ifdef FAST_LB_SOF_EN
    sof = s;
`endif
    e_valid = 1'b0;
    if (c) begin
      if (s) begin
        model_clear();
      end
      img[pr][pc] = d;
      if (pc >= 6 && pr >= 6) begin
        cx = pc - 3; cy = pr - 3;
        e_valid  = 1'b1;
        e_x      = 4'(cx);
        e_y      = 4'(cy);
        e_center = img[cy][cx];
        for (int i = 0; i < 16; i++)
          e_circle[i*PW +: PW] = img[cy + dy[i]][cx + dx[i]];
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
    if (e_valid) pulses++;
    if (c) begin
      pc++;
      if (pc == C) begin
        pc = 0;
        pr = (pr == R - 1) ? 0 : pr + 1;
      end
    end
  endtask

  task automatic feed(input int npix, input int gap_pct);
    int acc = 0;
    logic c;
    while (acc < npix) begin
      c = ($urandom_range(99) >= gap_pct);
      step(c, PW'($urandom), 1'b0);
      if (c) acc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b0;
`ifdef FAST_LB_SOF_EN
    sof = 1'b0;
`endif
    #2;
    e_valid = 1'b0; e_circle = '0; e_center = '0; e_x = '0; e_y = '0;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    rst = 1'b0;
    ce = 1'b0;
    data_in = '0;
`ifdef FAST_LB_SOF_EN
    sof = 1'b0;
`endif
    #1;
    do_reset();

    // Frame 1: ramp pattern, ce always high, with known-value spot checks.
    pulses = 0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        step(1'b1, PW'((r * 16 + c) & 8'hFF), 1'b0);
        if (r == 6 && c == 6) begin
          check("first_x", x_coord, 3);
          check("first_y", y_coord, 3);
          check("first_center", center_out, 51);
          check("first_slot0", circle_out[0*PW +: PW], 3);
          check("first_slot4", circle_out[4*PW +: PW], 54);
          check("first_slot8", circle_out[8*PW +: PW], 99);
          check("first_slot12", circle_out[12*PW +: PW], 48);
        end
        if (r == R - 1 && c == C - 1) begin
          check("last_x", x_coord, 12);
          check("last_y", y_coord, 8);
          check("last_center", center_out, 140);
        end
      end
    end
    check("frame1_pulses", pulses, 60);

    // Frame 2 straight after the wrap: random pixels, ~40% ce gaps.
    pulses = 0;
    feed(C * R, 40);
    check("frame2_pulses", pulses, 60);

    // Frame 3 interrupted by reset at pixel (9,8), then a fresh gapped frame.
    feed(8 * C + 9 + 1, 20);
    do_reset();
    pulses = 0;
    feed(C * R, 40);
    check("post_reset_pulses", pulses, 60);

`ifdef FAST_LB_SOF_EN
    // sof with ce low is ignored; sof with ce at (5,7) restarts the frame.
    feed(3 * C + 2, 30);
    step(1'b0, PW'($urandom), 1'b1);
    feed(4 * C + 3, 30);
    check("pre_sof_col", pc, 5);
    check("pre_sof_row", pr, 7);
    pulses = 0;
    step(1'b1, PW'($urandom), 1'b1);
    feed(C * R - 1, 40);
    check("sof_frame_pulses", pulses, 60);
`endif

    ce = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
